// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-requester async SRAM arbiter.
// Sizes the byte-cycle timing counter and picks the next enabled CPU byte lane.
package sram_arb_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD       = 3'd1;
  localparam state_t ST_WR_SETUP = 3'd2;
  localparam state_t ST_WR_PULSE = 3'd3;
  localparam state_t ST_WR_HOLD  = 3'd4;

  typedef enum logic {OWN_VID, OWN_CPU} owner_t;

  typedef logic [1:0] lane_t;

  localparam int RD_WAIT_DEF  = 1;
  localparam int WR_PULSE_DEF = 1;

  function automatic int cnt_width(input int rd_wait, input int wr_pulse);
    int m;
    m = (rd_wait > wr_pulse) ? rd_wait : wr_pulse;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int CNT_W = cnt_width(RD_WAIT_DEF, WR_PULSE_DEF);

  // Lowest set bit wins, so lanes are visited in ascending order.
  function automatic lane_t first_lane(input logic [3:0] m);
    lane_t l;
    l = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) l = lane_t'(i);
    end
    return l;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester buses (video, MCU) and SRAM pad signals of the arbiter.
// slave = arbiter side, master = requesters plus board/pad side.
interface sram_arbiter_if #(parameter int ADDR_W = 17);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_rdata;

  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_ble;
  logic [31:0]       cpu_wdata;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;

  logic [ADDR_W-1:0] sram_a;
  logic              sram_n_cs1;
  logic              sram_cs2;
  logic              sram_n_oe;
  logic              sram_n_we;
  logic [7:0]        sram_dq_o;
  logic              sram_dq_oe;
  logic [7:0]        sram_dq_i;

  modport slave (
    input  vid_req, vid_addr,
    output vid_ack, vid_rdata,
    input  cpu_req, cpu_write, cpu_addr, cpu_ble, cpu_wdata,
    output cpu_ready, cpu_rdata,
    output sram_a, sram_n_cs1, sram_cs2, sram_n_oe, sram_n_we, sram_dq_o, sram_dq_oe,
    input  sram_dq_i
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_ack, vid_rdata,
    output cpu_req, cpu_write, cpu_addr, cpu_ble, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    input  sram_a, sram_n_cs1, sram_cs2, sram_n_oe, sram_n_we, sram_dq_o, sram_dq_oe,
    output sram_dq_i
  );

endinterface

// File: rtl/sram_byte_cycle.sv
// One SRAM byte access per start: read = RD_WAIT+1 cycles, write = WR_PULSE+2 cycles.
// All pad controls come straight from flops; start is only honoured while idle.
module sram_byte_cycle
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              idle,
  output logic              done,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_n_cs1,
  output logic              sram_cs2,
  output logic              sram_n_oe,
  output logic              sram_n_we,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i
);

  localparam int CW = cnt_width(RD_WAIT, WR_PULSE);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [7:0]        dq_q, dq_d;
  logic              n_cs1_q, n_cs1_d;
  logic              cs2_q, cs2_d;
  logic              n_oe_q, n_oe_d;
  logic              n_we_q, n_we_d;
  logic              dq_oe_q, dq_oe_d;
  logic              sel;

  // Outputs are the registered image of the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    dq_d    = dq_q;
    sel     = 1'b1;
    n_oe_d  = 1'b1;
    n_we_d  = 1'b1;
    dq_oe_d = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel = 1'b0;
        if (start) begin
          sel = 1'b1;
          a_d = addr;
          if (wr) begin
            dq_d    = wdata;
            dq_oe_d = 1'b1;
            state_d = ST_WR_SETUP;
          end else begin
            n_oe_d  = 1'b0;
            cnt_d   = CW'(RD_WAIT);
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          sel     = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          n_oe_d = 1'b0;
        end
      end
      ST_WR_SETUP: begin
        dq_oe_d = 1'b1;
        n_we_d  = 1'b0;
        cnt_d   = CW'(WR_PULSE - 1);
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        dq_oe_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          n_we_d = 1'b0;
        end
      end
      ST_WR_HOLD: begin
        done    = 1'b1;
        sel     = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        sel     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    n_cs1_d = ~sel;
    cs2_d   = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      dq_q    <= '0;
      n_cs1_q <= 1'b1;
      cs2_q   <= 1'b0;
      n_oe_q  <= 1'b1;
      n_we_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      dq_q    <= dq_d;
      n_cs1_q <= n_cs1_d;
      cs2_q   <= cs2_d;
      n_oe_q  <= n_oe_d;
      n_we_q  <= n_we_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign idle       = (state_q == ST_IDLE);
  assign rdata      = sram_dq_i;
  assign sram_a     = a_q;
  assign sram_n_cs1 = n_cs1_q;
  assign sram_cs2   = cs2_q;
  assign sram_n_oe  = n_oe_q;
  assign sram_n_we  = n_we_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = dq_oe_q;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 8-bit async SRAM between video byte reads and MCU word accesses split into byte cycles.
// Video ack RD_WAIT+2 cycles after grant; requests are held until ack/ready, strict alternation under contention.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic            clk,
  input  logic            rst,
  sram_arbiter_if.slave   bus
);

  logic              bc_start, bc_wr, bc_idle, bc_done;
  logic [ADDR_W-1:0] bc_addr, cpu_word;
  logic [7:0]        bc_wdata, bc_rdata;
  logic [3:0]        pending;
  lane_t             nxt_lane;
  logic              vid_elig, cpu_elig, grant_vid, grant_cpu;

  owner_t            owner_q, owner_d;
  logic [3:0]        mask_q, mask_d;
  lane_t             lane_q, lane_d;
  logic              vid_ack_q, vid_ack_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;

  // A requester whose ack/ready is high this cycle is not eligible again until next cycle.
  always_comb begin
    vid_elig  = bus.vid_req && !vid_ack_q;
    cpu_elig  = bus.cpu_req && !cpu_ready_q;
    grant_cpu = bc_idle && cpu_elig && ((owner_q == OWN_VID) || !vid_elig);
    grant_vid = bc_idle && vid_elig && !grant_cpu;

    pending   = bus.cpu_ble & ~mask_q;
    nxt_lane  = first_lane(pending);

    cpu_word       = bus.cpu_addr;
    cpu_word[1:0]  = nxt_lane;

    bc_start = grant_vid || (grant_cpu && (pending != 4'd0));
    bc_wr    = grant_cpu && bus.cpu_write;
    bc_addr  = grant_cpu ? cpu_word : bus.vid_addr;
    bc_wdata = 8'(bus.cpu_wdata >> {nxt_lane, 3'b000});
  end

  always_comb begin
    owner_d     = owner_q;
    mask_d      = mask_q;
    lane_d      = lane_q;
    vid_ack_d   = 1'b0;
    vid_rdata_d = vid_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;

    if (bc_done) begin
      if (owner_q == OWN_VID) begin
        vid_ack_d   = 1'b1;
        vid_rdata_d = bc_rdata;
      end else begin
        if (!bus.cpu_write) begin
          for (int i = 0; i < 4; i++) begin
            if (lane_q == lane_t'(i)) cpu_rdata_d[8*i +: 8] = bc_rdata;
          end
        end
        mask_d = mask_q | (4'b0001 << lane_q);
        if ((bus.cpu_ble & ~mask_d) == 4'd0) begin
          cpu_ready_d = 1'b1;
          mask_d      = 4'd0;
        end
      end
    end

    if (grant_vid) owner_d = OWN_VID;

    // An empty mask marks the first lane of a word, so disabled lanes read back as zero.
    if (grant_cpu) begin
      owner_d = OWN_CPU;
      lane_d  = nxt_lane;
      if (mask_q == 4'd0) cpu_rdata_d = 32'd0;
      if (pending == 4'd0) cpu_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_CPU;
      mask_q      <= 4'd0;
      lane_q      <= 2'd0;
      vid_ack_q   <= 1'b0;
      vid_rdata_q <= 8'd0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 32'd0;
    end else begin
      owner_q     <= owner_d;
      mask_q      <= mask_d;
      lane_q      <= lane_d;
      vid_ack_q   <= vid_ack_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;

  sram_byte_cycle #(
    .ADDR_W   (ADDR_W),
    .RD_WAIT  (RD_WAIT),
    .WR_PULSE (WR_PULSE)
  ) u_cycle (
    .clk        (clk),
    .rst        (rst),
    .start      (bc_start),
    .wr         (bc_wr),
    .addr       (bc_addr),
    .wdata      (bc_wdata),
    .idle       (bc_idle),
    .done       (bc_done),
    .rdata      (bc_rdata),
    .sram_a     (bus.sram_a),
    .sram_n_cs1 (bus.sram_n_cs1),
    .sram_cs2   (bus.sram_cs2),
    .sram_n_oe  (bus.sram_n_oe),
    .sram_n_we  (bus.sram_n_we),
    .sram_dq_o  (bus.sram_dq_o),
    .sram_dq_oe (bus.sram_dq_oe),
    .sram_dq_i  (bus.sram_dq_i)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 128K x 8 SRAM on the pads.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(17)) bus();

  sram_arbiter #(.ADDR_W(17), .RD_WAIT(1), .WR_PULSE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:131071];

  wire sel = (bus.sram_n_cs1 === 1'b0) && (bus.sram_cs2 === 1'b1);
  assign bus.sram_dq_i = (sel && bus.sram_n_oe === 1'b0) ? mem[bus.sram_a] : 8'h00;

  always @(posedge clk) begin
    if (sel && bus.sram_n_we === 1'b0 && bus.sram_dq_oe === 1'b1) mem[bus.sram_a] <= bus.sram_dq_o;
  end

  // Pad monitor: counts are read by the stimulus only at posedge+1.
  int cyc = 0, oe_low = 0, we_low = 0, we_pulses = 0, cs_cyc = 0, ack_cnt = 0, rdy_cnt = 0, st_n = 0;
  logic [16:0] st_a [0:255];
  int          st_t [0:255];
  bit prev_sel = 1'b0, prev_we = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (bus.sram_n_oe === 1'b0) oe_low++;
    if (bus.sram_n_we === 1'b0) begin
      we_low++;
      if (prev_we) we_pulses++;
    end
    if (sel) cs_cyc++;
    if (sel && !prev_sel && st_n < 256) begin
      st_a[st_n] = bus.sram_a;
      st_t[st_n] = cyc;
      st_n++;
    end
    if (bus.vid_ack === 1'b1) ack_cnt++;
    if (bus.cpu_ready === 1'b1) rdy_cnt++;
    prev_sel = sel;
    prev_we  = (bus.sram_n_we !== 1'b0);
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind 0: vid_ack, 1: cpu_ready, 2: n_we low. n = cycles after the request cycle.
  task automatic wait_evt(input int kind, input string tag, input int limit, output int n);
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n <= limit) begin
      @(negedge clk);
      case (kind)
        0:       hit = (bus.vid_ack === 1'b1);
        1:       hit = (bus.cpu_ready === 1'b1);
        default: hit = (bus.sram_n_we === 1'b0);
      endcase
      if (!hit) n++;
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic cpu_go(input logic wr, input logic [16:0] addr, input logic [3:0] ble,
                        input logic [31:0] wdata);
    @(posedge clk); #1;
    bus.cpu_write = wr;
    bus.cpu_addr  = addr;
    bus.cpu_ble   = ble;
    bus.cpu_wdata = wdata;
    bus.cpu_req   = 1'b1;
  endtask

  task automatic cpu_drop();
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int n, oe0, we0, wp0, cs0, ack0, rdy0, st0, gap;
  logic [16:0] exp_a;

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h00100] = 8'hA5;
    mem[17'h00041] = 8'hEE;
    mem[17'h00043] = 8'hEE;
    rst = 1'b1;
    bus.vid_req = 1'b0;  bus.vid_addr = '0;
    bus.cpu_req = 1'b0;  bus.cpu_write = 1'b0; bus.cpu_addr = '0;
    bus.cpu_ble = 4'h0;  bus.cpu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_n_cs1", bus.sram_n_cs1, 1);
    check("rst_cs2", bus.sram_cs2, 0);
    check("rst_n_oe", bus.sram_n_oe, 1);
    check("rst_n_we", bus.sram_n_we, 1);
    check("rst_dq_oe", bus.sram_dq_oe, 0);
    check("rst_a", bus.sram_a, 0);
    check("rst_dq_o", bus.sram_dq_o, 0);
    check("rst_vid_ack", bus.vid_ack, 0);
    check("rst_cpu_ready", bus.cpu_ready, 0);
    check("rst_vid_rdata", bus.vid_rdata, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);

    // Video-only read
    @(posedge clk); #1;
    oe0 = oe_low; we0 = we_low; ack0 = ack_cnt;
    bus.vid_addr = 17'h00100;
    bus.vid_req  = 1'b1;
    wait_evt(0, "vid_lat", 20, n);
    check("vid_lat", n, 3);
    check("vid_rdata", bus.vid_rdata, 8'hA5);
    @(posedge clk); #1 bus.vid_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("vid_oe_cycles", oe_low - oe0, 2);
    check("vid_we_cycles", we_low - we0, 0);
    check("vid_ack_count", ack_cnt - ack0, 1);

    // Sparse write, lanes 0 and 2
    we0 = we_low; wp0 = we_pulses; rdy0 = rdy_cnt;
    cpu_go(1'b1, 17'h00040, 4'b0101, 32'h11223344);
    wait_evt(1, "wr_sparse_lat", 40, n);
    check("wr_sparse_lat", n, 8);
    cpu_drop();
    check("wr_sparse_m40", mem[17'h00040], 8'h44);
    check("wr_sparse_m41", mem[17'h00041], 8'hEE);
    check("wr_sparse_m42", mem[17'h00042], 8'h22);
    check("wr_sparse_m43", mem[17'h00043], 8'hEE);
    check("wr_sparse_pulses", we_pulses - wp0, 2);
    check("wr_sparse_we_cycles", we_low - we0, 2);
    check("wr_sparse_ready_count", rdy_cnt - rdy0, 1);

    // Full-word write then read back
    cpu_go(1'b1, 17'h00040, 4'hF, 32'h04030201);
    wait_evt(1, "wr_full_lat", 40, n);
    check("wr_full_lat", n, 16);
    cpu_drop();
    check("wr_full_m43", mem[17'h00043], 8'h04);

    cpu_go(1'b0, 17'h00040, 4'hF, 32'h0);
    wait_evt(1, "rd_full_lat", 40, n);
    check("rd_full_lat", n, 12);
    check("rd_full_data", bus.cpu_rdata, 32'h04030201);
    cpu_drop();

    // Contention: video held continuously plus a full-word CPU read
    st0 = st_n; ack0 = ack_cnt;
    @(posedge clk); #1;
    bus.vid_addr  = 17'h00100;
    bus.vid_req   = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = 17'h00040;
    bus.cpu_ble   = 4'hF;
    bus.cpu_req   = 1'b1;
    wait_evt(1, "cont_lat", 80, n);
    check("cont_lat", n, 24);
    check("cont_rdata", bus.cpu_rdata, 32'h04030201);
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    wait_evt(0, "cont_vid_tail", 20, n);
    @(posedge clk); #1 bus.vid_req = 1'b0;
    check("cont_vid_rdata", bus.vid_rdata, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      exp_a = (i % 2 == 0) ? 17'h00100 : 17'(17'h00040 + i / 2);
      check($sformatf("cont_grant%0d", i), st_a[st0 + i], exp_a);
    end
    for (int k = 0; k < 3; k++) begin
      gap = st_t[st0 + 2*k + 2] - st_t[st0 + 2*k];
      check($sformatf("cont_vid_gap%0d_le6", k), (gap <= 6), 1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("cont_ack_count", ack_cnt - ack0, 5);

    // Empty byte-lane mask
    cs0 = cs_cyc; rdy0 = rdy_cnt; we0 = we_low;
    cpu_go(1'b1, 17'h00040, 4'b0000, 32'hDEADBEEF);
    wait_evt(1, "ble0_lat", 10, n);
    check("ble0_lat", n, 1);
    cpu_drop();
    check("ble0_cs_cycles", cs_cyc - cs0, 0);
    check("ble0_we_cycles", we_low - we0, 0);
    check("ble0_ready_count", rdy_cnt - rdy0, 1);

    // Reset during the write pulse
    rdy0 = rdy_cnt;
    cpu_go(1'b1, 17'h00040, 4'b0001, 32'h00000001);
    wait_evt(2, "rst_we_seen", 20, n);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rstmid_n_we", bus.sram_n_we, 1);
    check("rstmid_dq_oe", bus.sram_dq_oe, 0);
    check("rstmid_n_cs1", bus.sram_n_cs1, 1);
    check("rstmid_cs2", bus.sram_cs2, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_ready", rdy_cnt - rdy0, 0);

    cpu_go(1'b0, 17'h00040, 4'hF, 32'h0);
    wait_evt(1, "post_rst_lat", 40, n);
    check("post_rst_lat", n, 12);
    check("post_rst_data", bus.cpu_rdata, 32'h04030201);
    cpu_drop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
